// File: rtl/mux_nto1_serializer.sv
// N-lane to 1-lane serializer with SLOT/PACK modes and out_ready backpressure.
// Optional MUX_LANE_TAG_EN adds out_lane, the source lane of each beat.
module mux_nto1_serializer #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                        clk_4f,
  input  logic                        reset,
  input  logic                        mode_pack,
  input  logic                        in_load,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_empty,
`ifdef MUX_LANE_TAG_EN
  output logic [LANE_W-1:0]           out_lane,
`endif
  output logic                        out_last
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                      state;
  logic [NUM_LANES*DATA_W-1:0] data_q;
  logic [NUM_LANES-1:0]        mask_q;
  logic [NUM_LANES-1:0]        vld_q;
  logic                        mode_q;

  logic                        accept;
  logic                        beat_acc;
  logic [NUM_LANES-1:0]        src_mask;
  logic [NUM_LANES*DATA_W-1:0] src_data;
  logic [NUM_LANES-1:0]        src_vld;
  logic                        src_mode;
  logic [LANE_W-1:0]           nxt_lane;
  logic                        nxt_any;
  logic                        nxt_last;
  logic                        nxt_vbit;
  logic [DATA_W-1:0]           nxt_byte;

  assign in_ready = !reset &&
                    (state == IDLE ||
                     (out_last && out_ready));
  assign accept   = in_load && in_ready;
  assign beat_acc = (state == SHIFT) && out_ready;

  // A new word takes priority; otherwise drop the lane just emitted
  always_comb begin
    src_mask = '0;
    src_data = data_q;
    src_vld  = vld_q;
    src_mode = mode_q;
    unique case (1'b1)
      accept: begin
        src_mask = mode_pack ? in_valid : '1;
        src_data = in_data;
        src_vld  = in_valid;
        src_mode = mode_pack;
      end
      default: begin
        src_mask = mask_q & (mask_q - 1'b1);
      end
    endcase
  end

  always_comb begin
    nxt_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (src_mask[i]) nxt_lane = LANE_W'(i);
    end
  end

  assign nxt_any  = |src_mask;
  assign nxt_last = nxt_any &&
                    ((src_mask & (src_mask - 1'b1)) == '0);
  assign nxt_vbit = src_vld[nxt_lane];
  assign nxt_byte = src_data[nxt_lane*DATA_W +: DATA_W];

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      vld_q     <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_empty <= 1'b0;
      out_last  <= 1'b0;
`ifdef MUX_LANE_TAG_EN
      out_lane  <= '0;
`endif
    end else if (accept || beat_acc) begin
      data_q <= src_data;
      vld_q  <= src_vld;
      mode_q <= src_mode;
      mask_q <= src_mask;
      if (nxt_any) begin
        state     <= SHIFT;
        out_valid <= 1'b1;
        out_data  <= (src_mode || nxt_vbit) ? nxt_byte : '0;
        out_empty <= !src_mode && !nxt_vbit;
        out_last  <= nxt_last;
`ifdef MUX_LANE_TAG_EN
        out_lane  <= nxt_lane;
`endif
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_empty <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_serializer.sv
// Scoreboard bench for mux_nto1_serializer (4 lanes x 8 bits).
// Directed words push expected beats; a negedge monitor pops and compares.
module tb_mux_nto1_serializer;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic        mode_pack;
  logic        in_load;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_empty;
  logic        out_last;
`ifdef MUX_LANE_TAG_EN
  logic [1:0]  out_lane;
`endif

  mux_nto1_serializer #(.NUM_LANES(4), .DATA_W(8)) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .mode_pack(mode_pack),
    .in_load  (in_load),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_empty(out_empty),
`ifdef MUX_LANE_TAG_EN
    .out_lane (out_lane),
`endif
    .out_last (out_last)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       l;
    logic [1:0] ln;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic e,
                      input logic l, input logic [1:0] ln);
    beat_t b;
    b.d = d; b.e = e; b.l = l; b.ln = ln;
    sb.push_back(b);
  endtask

  always @(negedge clk_4f) begin : monitor
    beat_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", int'(out_data), -1);
      end else begin
        e = sb.pop_front();
        chk("beat_data", int'(out_data), int'(e.d));
        chk("beat_empty", int'(out_empty), int'(e.e));
        chk("beat_last", int'(out_last), int'(e.l));
`ifdef MUX_LANE_TAG_EN
        chk("beat_lane", int'(out_lane), int'(e.ln));
`endif
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic load(input logic m, input logic [3:0] v,
                      input logic [31:0] d);
    bit ok = 0;
    in_load = 1'b1; mode_pack = m; in_valid = v; in_data = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_4f);
      if (in_ready) begin ok = 1; break; end
    end
    chk("load_accepted", int'(ok), 1);
    @(posedge clk_4f); #1;
    in_load = 1'b0; in_valid = 4'h0; in_data = 32'h0;
  endtask

  // Counts contiguous valid cycles starting at the next negedge
  task automatic wait_idle(input string name, input int exp);
    int cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_4f);
      if (!out_valid) break;
      cnt++;
    end
    chk(name, cnt, exp);
  endtask

  initial begin
    reset = 1'b1; mode_pack = 1'b0; in_load = 1'b0;
    in_valid = 4'h0; in_data = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_empty", int'(out_empty), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk_4f); #1; reset = 1'b0;
    @(negedge clk_4f);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk_4f); #1;

    // SLOT, all lanes valid
    load(1'b0, 4'b1111, 32'h44332211);
    push(8'h11, 0, 0, 0); push(8'h22, 0, 0, 1);
    push(8'h33, 0, 0, 2); push(8'h44, 0, 1, 3);
    wait_idle("slot_full_cycles", 4);
    @(posedge clk_4f); #1;

    // SLOT with gaps
    load(1'b0, 4'b0101, 32'h44332211);
    push(8'h11, 0, 0, 0); push(8'h00, 1, 0, 1);
    push(8'h33, 0, 0, 2); push(8'h00, 1, 1, 3);
    wait_idle("slot_gap_cycles", 4);
    @(posedge clk_4f); #1;

    // PACK 1010
    load(1'b1, 4'b1010, 32'hA3A2A1A0);
    push(8'hA1, 0, 0, 1); push(8'hA3, 0, 1, 3);
    wait_idle("pack_cycles", 2);
    @(posedge clk_4f); #1;

    // PACK with nothing valid
    load(1'b1, 4'b0000, 32'hDEADBEEF);
    @(negedge clk_4f);
    chk("pack_zero_valid", int'(out_valid), 0);
    chk("pack_zero_ready", int'(in_ready), 1);
    @(posedge clk_4f); #1;

    // Stall mid-word, then back-to-back second word
    load(1'b0, 4'b1111, 32'h44332211);
    push(8'h11, 0, 0, 0); push(8'h22, 0, 0, 1);
    push(8'h33, 0, 0, 2); push(8'h44, 0, 1, 3);
    @(negedge clk_4f);
    @(posedge clk_4f); #1; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk_4f);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), 8'h22);
      chk("stall_last", int'(out_last), 0);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk_4f); #1; out_ready = 1'b1;
    load(1'b0, 4'b1111, 32'h88776655);
    chk("b2b_first_pending", sb.size(), 0);
    push(8'h55, 0, 0, 0); push(8'h66, 0, 0, 1);
    push(8'h77, 0, 0, 2); push(8'h88, 0, 1, 3);
    wait_idle("b2b_second_cycles", 4);
    @(posedge clk_4f); #1;

    // Reset mid-word
    load(1'b0, 4'b1111, 32'h44332211);
    push(8'h11, 0, 0, 0); push(8'h22, 0, 0, 1);
    @(negedge clk_4f);
    @(posedge clk_4f); #1;
    @(negedge clk_4f);
    @(posedge clk_4f); #1; reset = 1'b1;
    @(negedge clk_4f);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk_4f); #1;
    sb.delete();
    @(negedge clk_4f);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_last", int'(out_last), 0);
    chk("midrst_out_data", int'(out_data), 0);
    @(posedge clk_4f); #1; reset = 1'b0;
    load(1'b0, 4'b1111, 32'hDDCCBBAA);
    push(8'hAA, 0, 0, 0); push(8'hBB, 0, 0, 1);
    push(8'hCC, 0, 0, 2); push(8'hDD, 0, 1, 3);
    wait_idle("after_rst_cycles", 4);

    repeat (2) @(negedge clk_4f);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
